// File: rtl/password_pkg.sv
// password_pkg -- shared types and constants for the password enrollment block.
//   state_t      : controller states
//   SEG_*        : active-low gfedcba seven-segment glyphs
//   NUM_DIGITS   : digits per code, DIGIT_W : bits per digit
//   thermo()     : n -> n-bit thermometer (LSB first), saturating at NUM_DIGITS
package password_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int CODE_W     = NUM_DIGITS * DIGIT_W;
   localparam int NUM_SW     = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTER,
      ST_CONFIRM,
      ST_DONE,
      ST_FAIL
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_O     = 7'b0100011;
   localparam logic [6:0] SEG_N     = 7'b0101011;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_R     = 7'b0101111;

   function automatic logic [NUM_DIGITS-1:0] thermo(input logic [2:0] n);
      logic [NUM_DIGITS:0] t;
      t = (NUM_DIGITS+1)'((5'd1 << n) - 5'd1);
      return t[NUM_DIGITS-1:0];
   endfunction

endpackage

// File: rtl/sw_edge_sync.sv
// sw_edge_sync -- two-flop synchronizer followed by a previous-value register.
//   clk, reset     : clock, asynchronous active-high reset
//   async_in[W]    : raw asynchronous levels
//   sync_out[W]    : synchronized level
//   rise[W]        : one-cycle rising-edge strobe (sync & ~prev)
// All flops reset to ones so an input already high when reset releases
// never looks like a fresh rising edge.
module sw_edge_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] prev_q, prev_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '1;
         sync_q <= '1;
         prev_q <= '1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_out = sync_q;
   assign rise     = sync_q & ~prev_q;

endmodule

// File: rtl/password_enroll.sv
// password_enroll -- enrolls a new 4-digit code entered twice on switches.
//   clk, reset        : clock, asynchronous active-high reset
//   sw[8:0]           : raw switches, a rising edge on sw[i] enters digit i
//   prog_en           : raw enroll-mode switch
//   code[15:0]        : committed code, digit0 in [3:0]
//   code_valid        : one-cycle pulse when code is updated
//   busy              : high in ENTER, CONFIRM, DONE, FAIL
//   hex0..hex4        : active-low gfedcba displays (DONE / Err messages)
//   ledr[9:0]         : [3:0] progress, [4] confirming, [8] busy, [9] prog_en
// Every output is a flop loaded from the next-state values, so displays and
// LEDs change on the same edge as the state they describe.
module password_enroll
   import password_pkg::*;
#(
   parameter int          HOLD_CYCLES  = 50_000_000,
   parameter logic [15:0] DEFAULT_CODE = 16'h3210
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  sw,
   input  logic        prog_en,
   output logic [15:0] code,
   output logic        code_valid,
   output logic        busy,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [9:0]  ledr
);

   localparam int TIMER_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_CYCLES - 1);

   // ---------------- input conditioning ----------------
   logic [NUM_SW-1:0] sw_sync;
   logic [NUM_SW-1:0] sw_rise;
   logic              prog_sync;
   logic              prog_rise;

   sw_edge_sync #(.WIDTH(NUM_SW)) u_sw_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (sw),
      .sync_out (sw_sync),
      .rise     (sw_rise)
   );

   sw_edge_sync #(.WIDTH(1)) u_prog_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (prog_en),
      .sync_out (prog_sync),
      .rise     (prog_rise)
   );

   // Digit value of the (single) rising switch; only meaningful when
   // exactly one edge is present.
   logic [NUM_SW-1:0][DIGIT_W-1:0] idx_terms;
   logic [DIGIT_W-1:0]             digit;
   logic                           one_edge;
   logic                           multi_edge;

   generate
      for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_idx
         assign idx_terms[gi] = sw_rise[gi] ? DIGIT_W'(gi) : '0;
      end
   endgenerate

   always_comb begin
      digit = '0;
      for (int i = 0; i < NUM_SW; i++) begin
         digit = digit | idx_terms[i];
      end
   end

   assign one_edge   = $onehot(sw_rise);
   assign multi_edge = (|sw_rise) && !one_edge;

   // ---------------- state ----------------
   state_t               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [CODE_W-1:0]    tmp_q, tmp_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [CODE_W-1:0]    code_q, code_d;
   logic                 code_valid_q, code_valid_d;
   logic                 busy_q, busy_d;
   logic [4:0][6:0]      hex_q, hex_d;
   logic [9:0]           ledr_q, ledr_d;

   logic [DIGIT_W-1:0]   tmp_digit;
   logic                 last_digit;

   assign tmp_digit  = tmp_q[{cnt_q, 2'b00} +: DIGIT_W];
   assign last_digit = (cnt_q == 2'(NUM_DIGITS - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tmp_d        = tmp_q;
      timer_d      = timer_q;
      code_d       = code_q;
      code_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            tmp_d   = '0;
            timer_d = '0;
            if (prog_rise) begin
               state_d = ST_ENTER;
            end
         end

         ST_ENTER: begin
            // Leaving enroll mode abandons the pass silently.
            if (!prog_sync) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               tmp_d   = '0;
            end else if (multi_edge) begin
               state_d = ST_FAIL;
               cnt_d   = '0;
            end else if (one_edge) begin
               tmp_d[{cnt_q, 2'b00} +: DIGIT_W] = digit;
               if (last_digit) begin
                  state_d = ST_CONFIRM;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end

         ST_CONFIRM: begin
            if (!prog_sync) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               tmp_d   = '0;
            end else if (multi_edge || (one_edge && digit != tmp_digit)) begin
               state_d = ST_FAIL;
               cnt_d   = '0;
            end else if (one_edge) begin
               if (last_digit) begin
                  state_d      = ST_DONE;
                  cnt_d        = '0;
                  code_d       = tmp_q;
                  code_valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end

         ST_DONE, ST_FAIL: begin
            if (timer_q == TIMER_LAST) begin
               state_d = ST_IDLE;
               timer_d = '0;
               tmp_d   = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmp_d   = '0;
            timer_d = '0;
         end
      endcase
   end

   // ---------------- registered output decode ----------------
   always_comb begin
      busy_d = (state_d != ST_IDLE);

      hex_d = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
      if (state_d == ST_DONE) begin
         hex_d = {SEG_BLANK, SEG_D, SEG_O, SEG_N, SEG_E};
      end else if (state_d == ST_FAIL) begin
         hex_d = {SEG_BLANK, SEG_BLANK, SEG_E, SEG_R, SEG_R};
      end

      ledr_d = '0;
      if (state_d == ST_DONE) begin
         ledr_d[3:0] = '1;
      end else if (state_d != ST_FAIL) begin
         ledr_d[3:0] = thermo({1'b0, cnt_d});
      end
      ledr_d[4] = (state_d == ST_CONFIRM);
      ledr_d[8] = busy_d;
      ledr_d[9] = prog_sync;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         tmp_q        <= '0;
         timer_q      <= '0;
         code_q       <= DEFAULT_CODE;
         code_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         hex_q        <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK};
         ledr_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tmp_q        <= tmp_d;
         timer_q      <= timer_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         busy_q       <= busy_d;
         hex_q        <= hex_d;
         ledr_q       <= ledr_d;
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign busy       = busy_q;
   assign hex0       = hex_q[0];
   assign hex1       = hex_q[1];
   assign hex2       = hex_q[2];
   assign hex3       = hex_q[3];
   assign hex4       = hex_q[4];
   assign ledr       = ledr_q;

endmodule

// File: doc/password_enroll.md
PASSWORD_ENROLL -- requirements
Module: password_enroll

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, cycles DONE/FAIL message is held before returning to IDLE.
REQ-002 SHALL have parameter DEFAULT_CODE, default 16'h3210, code loaded at reset (digit0 in [3:0]).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw  input  9  raw asynchronous switch levels; a digit is a rising edge on sw[i] (value i).
REQ-006 SHALL have port prog_en  input  1  raw asynchronous enroll-mode switch.
REQ-007 SHALL have port code  output  16  committed 4-digit code, 4 bits per digit, digit0 in [3:0].
REQ-008 SHALL have port code_valid  output  1  one-cycle pulse when code is updated.
REQ-009 SHALL have port busy  output  1  high in ENTER, CONFIRM, DONE, FAIL.
REQ-010 SHALL have ports hex0..hex4  output  7 each  active-low gfedcba seven-segment drive.
REQ-011 SHALL have port ledr  output  10  progress LEDs.

Function
REQ-012 sw and prog_en SHALL each pass a 2-flop synchronizer, then a previous-value register; edge = sync & ~prev.
REQ-013 States: IDLE, ENTER, CONFIRM, DONE, FAIL; 2-bit digit counter cnt; 16-bit scratch register tmp.
REQ-014 IDLE: synchronized prog_en rising edge -> ENTER, cnt=0; sw edges ignored.
REQ-015 ENTER: exactly one sw edge -> tmp digit[cnt]=its index, cnt+1; after 4th digit -> CONFIRM, cnt=0.
REQ-016 CONFIRM: exactly one sw edge equal to tmp digit[cnt] -> cnt+1; on 4th match -> DONE; code<=tmp, code_valid=1 for exactly the transition cycle's following cycle.
REQ-017 ENTER/CONFIRM: two or more sw edges in one cycle, or a CONFIRM mismatch -> FAIL; code unchanged.
REQ-018 ENTER/CONFIRM: synchronized prog_en low -> IDLE, tmp discarded, code unchanged, no FAIL.
REQ-019 DONE/FAIL: hold timer counts HOLD_CYCLES then -> IDLE; sw and prog_en ignored meanwhile.
REQ-020 A digit SHALL be registered within 3 clk cycles of its raw sw rising edge (2 sync + 1 state).
REQ-021 Falling sw edges and sw held high SHALL never produce digits.
REQ-022 hex: IDLE/ENTER/CONFIRM all blank 1111111; DONE hex4..0 = blank,d 0100001,o 0100011,n 0101011,E 0000110; FAIL hex4..0 = blank,blank,E 0000110,r 0101111,r 0101111.
REQ-023 ledr[3:0] SHALL be thermometer of cnt digits captured in current pass (all ones in DONE, zero in FAIL); ledr[4] high in CONFIRM; ledr[8]=busy; ledr[9]=synchronized prog_en; other bits 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 reset SHALL force IDLE, cnt=0, tmp=0, timer=0, code=DEFAULT_CODE, code_valid=0, busy=0, hex blank, ledr=0.
REQ-026 Synchronizer and previous-value flops SHALL reset to all ones so switches high at reset release yield no edge.
REQ-027 reset mid-enrollment SHALL discard tmp and restore DEFAULT_CODE.

Structure
REQ-028 Package password_pkg SHALL hold state enum, segment constants (BLANK, d, o, n, E, r), NUM_DIGITS=4, DIGIT_W=4.
REQ-029 Sub-module sw_edge_sync (parameter width) SHALL implement REQ-012/REQ-026; instantiated for sw and prog_en.

Verification (HOLD_CYCLES=16)
REQ-030 prog_en up; sw edges 5,2,7,1 then 5,2,7,1 -> code=16'h1725, one code_valid pulse, DONE pattern for 16 cycles, then IDLE.
REQ-031 Enter 5,2,7,1, confirm 5,2,8 -> FAIL pattern, code stays 16'h3210, code_valid never asserts.
REQ-032 In ENTER, sw[3] and sw[4] rise same cycle -> FAIL; ledr[3:0]=0.
REQ-033 After 2 digits, prog_en drops -> IDLE within 3 cycles, hex blank, code unchanged.
REQ-034 sw[0] held high across reset release, then prog_en up -> no digit until sw[0] falls and rises again.
REQ-035 reset asserted in CONFIRM after 3 matches -> immediate IDLE, code=16'h3210, outputs at reset values.
